// File: rtl/match_controller.sv
// Match sequencing for a multi-paddle ball game: per-frame hit/miss detection,
// scoring with a last-hitter rule, and point / game-over pauses counted in frames.
module match_controller #(
    parameter int NUM_PLAYERS   = 2,
    parameter int SCORE_W       = 4,
    parameter int WIN_SCORE     = 7,
    parameter int POINT_PAUSE   = 64,
    parameter int RESTART_PAUSE = 128
) (
    input  logic                               pixel_clk,
    input  logic                               rst_n,
    input  logic                               fsync,
    input  logic                               start,
    input  logic                               active_obj,
    input  logic [NUM_PLAYERS-1:0]             active_paddle,
    input  logic [NUM_PLAYERS-1:0]             goal_zone,
    output logic [NUM_PLAYERS*SCORE_W-1:0]     score,
    output logic                               obj_hold,
    output logic                               point_pulse,
    output logic                               game_over,
    output logic [$clog2(NUM_PLAYERS)-1:0]     winner,
    output logic [1:0]                         state
);
    localparam int IDX_W     = $clog2(NUM_PLAYERS);
    localparam int MAX_PAUSE = (POINT_PAUSE > RESTART_PAUSE) ? POINT_PAUSE : RESTART_PAUSE;
    localparam int CNT_W     = $clog2(MAX_PAUSE + 1);
    localparam logic [SCORE_W-1:0] WIN_VAL      = SCORE_W'(WIN_SCORE);
    localparam logic [CNT_W-1:0]   POINT_LAST   = CNT_W'(POINT_PAUSE - 1);
    localparam logic [CNT_W-1:0]   RESTART_LAST = CNT_W'(RESTART_PAUSE - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, POINT = 2'd2, OVER = 2'd3} state_t;

    state_t                                 state_reg, state_next;
    logic [NUM_PLAYERS-1:0][SCORE_W-1:0]    score_reg, score_next;
    logic [NUM_PLAYERS-1:0]                 hit_seen_reg, hit_seen_next;
    logic [NUM_PLAYERS-1:0]                 miss_seen_reg, miss_seen_next;
    logic [IDX_W-1:0]                       last_hitter_reg, last_hitter_next;
    logic                                   last_valid_reg, last_valid_next;
    logic [CNT_W-1:0]                       cnt_reg, cnt_next;
    logic                                   obj_hold_reg, obj_hold_next;
    logic                                   point_pulse_reg, point_pulse_next;
    logic                                   game_over_reg, game_over_next;
    logic [IDX_W-1:0]                       winner_reg, winner_next;

    logic [NUM_PLAYERS-1:0] hit_now, miss_now, miss_mask;
    logic [IDX_W-1:0]       hit_idx, miss_idx, lh_eff;
    logic                   lv_eff;
    logic [SCORE_W-1:0]     cur_score, inc_score;

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            score_reg       <= '0;
            hit_seen_reg    <= '0;
            miss_seen_reg   <= '0;
            last_hitter_reg <= '0;
            last_valid_reg  <= 1'b0;
            cnt_reg         <= '0;
            obj_hold_reg    <= 1'b1;
            point_pulse_reg <= 1'b0;
            game_over_reg   <= 1'b0;
            winner_reg      <= '0;
        end else begin
            state_reg       <= state_next;
            score_reg       <= score_next;
            hit_seen_reg    <= hit_seen_next;
            miss_seen_reg   <= miss_seen_next;
            last_hitter_reg <= last_hitter_next;
            last_valid_reg  <= last_valid_next;
            cnt_reg         <= cnt_next;
            obj_hold_reg    <= obj_hold_next;
            point_pulse_reg <= point_pulse_next;
            game_over_reg   <= game_over_next;
            winner_reg      <= winner_next;
        end
    end

    always_comb begin
        hit_now  = goal_zone & active_paddle & {NUM_PLAYERS{active_obj}};
        miss_now = goal_zone & ~active_paddle & {NUM_PLAYERS{active_obj}};
        // The fsync pixel already belongs to the new frame.
        hit_seen_next  = fsync ? hit_now  : (hit_seen_reg  | hit_now);
        miss_seen_next = fsync ? miss_now : (miss_seen_reg | miss_now);

        // A goal that saw both a hit and a miss in one frame counts as a hit.
        miss_mask = miss_seen_reg & ~hit_seen_reg;
        hit_idx   = '0;
        miss_idx  = '0;
        for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
            if (hit_seen_reg[i]) hit_idx  = IDX_W'(i);
            if (miss_mask[i])    miss_idx = IDX_W'(i);
        end
        // A hit in the finished frame updates the hitter before the miss is judged.
        lh_eff    = (|hit_seen_reg) ? hit_idx : last_hitter_reg;
        lv_eff    = (|hit_seen_reg) | last_valid_reg;
        cur_score = score_reg[lh_eff];
        inc_score = cur_score + SCORE_W'(1);

        state_next       = state_reg;
        score_next       = score_reg;
        last_hitter_next = last_hitter_reg;
        last_valid_next  = last_valid_reg;
        cnt_next         = cnt_reg;
        point_pulse_next = 1'b0;
        game_over_next   = game_over_reg;
        winner_next      = winner_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    score_next      = '0;
                    last_valid_next = 1'b0;
                    state_next      = PLAY;
                end
            end
            PLAY: begin
                if (fsync) begin
                    last_hitter_next = lh_eff;
                    last_valid_next  = lv_eff;
                    if (|miss_mask) begin
                        point_pulse_next = 1'b1;
                        last_valid_next  = 1'b0;
                        state_next       = POINT;
                        if (lv_eff && (lh_eff != miss_idx) && (cur_score != WIN_VAL)) begin
                            score_next[lh_eff] = inc_score;
                            if (inc_score == WIN_VAL) begin
                                state_next     = OVER;
                                winner_next    = lh_eff;
                                game_over_next = 1'b1;
                            end
                        end
                    end
                end
            end
            POINT: begin
                if (fsync) begin
                    if (cnt_reg == POINT_LAST) state_next = PLAY;
                    else                       cnt_next   = cnt_reg + CNT_W'(1);
                end
            end
            OVER: begin
                if (fsync) begin
                    if (cnt_reg == RESTART_LAST) begin
                        state_next     = IDLE;
                        game_over_next = 1'b0;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
            end
        endcase

        if (state_next != state_reg) cnt_next = '0;
        obj_hold_next = (state_next != PLAY);
    end

    assign score       = score_reg;
    assign obj_hold    = obj_hold_reg;
    assign point_pulse = point_pulse_reg;
    assign game_over   = game_over_reg;
    assign winner      = winner_reg;
    assign state       = state_reg;

endmodule
